// File: rtl/joy_shiftreg_responder_pkg.sv
// Shared definitions for the ZX3 serial joystick link (responder side).
// Button ordering and chain offsets must match the decoder end of the link.
package joy_shiftreg_responder_pkg;

    // Button bit indices inside one pad byte
    localparam int JOY_UP_BIT     = 7;
    localparam int JOY_DOWN_BIT   = 6;
    localparam int JOY_LEFT_BIT   = 5;
    localparam int JOY_RIGHT_BIT  = 4;
    localparam int JOY_FIRE1_BIT  = 3;
    localparam int JOY_FIRE2_BIT  = 2;
    localparam int JOY_FIRE3_BIT  = 1;
    localparam int JOY_START_BIT  = 0;

    // Pad byte positions within the 16-bit load word (joy1 shifts out first)
    localparam int JOY1_OFFSET    = 8;
    localparam int JOY2_OFFSET    = 0;
    localparam int PAD_WORD_BITS  = 16;

    localparam int DEFAULT_CHAIN_BITS = 16;

    // Builds the active-low load word from two active-high pad bytes
    function automatic logic [PAD_WORD_BITS-1:0] pack_chain(
        input logic [7:0] pad1,
        input logic [7:0] pad2
    );
        logic [PAD_WORD_BITS-1:0] word;
        word = {PAD_WORD_BITS{1'b1}};
        word[JOY1_OFFSET +: 8] = ~pad1;
        word[JOY2_OFFSET +: 8] = ~pad2;
        return word;
    endfunction

endpackage

// File: rtl/joy_shiftreg_responder_sync_edge.sv
// Multi-stage synchroniser for an asynchronous line followed by one
// edge-detect register. Level and edge pulses are all registered and aligned.
module joy_shiftreg_responder_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;
    logic                   rise_r;
    logic                   fall_r;
    logic                   sync_out_s;

    assign sync_out_s = sync_r[SYNC_STAGES-1];

    // Synchroniser chain; resets to the idle level so reset release makes no edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_r <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], async_in};
        end
    end

    // Edge-detect stage: delayed level plus registered rise/fall pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_r <= RESET_VAL;
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end else begin
            prev_r <= sync_out_s;
            rise_r <= sync_out_s & ~prev_r;
            fall_r <= ~sync_out_s & prev_r;
        end
    end

    assign level = prev_r;
    assign rise  = rise_r;
    assign fall  = fall_r;

endmodule

// File: rtl/joy_shiftreg_responder.sv
// Device end of the ZX3 serial joystick link: emulates a 74HC165 chain that
// an external decoder loads with joy_load_n and clocks with joy_clk.
module joy_shiftreg_responder
    import joy_shiftreg_responder_pkg::*;
#(
    parameter int CHAIN_BITS     = DEFAULT_CHAIN_BITS,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1600000
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [7:0]                       joy1,
    input  logic [7:0]                       joy2,
    input  logic                             joy_clk,
    input  logic                             joy_load_n,
    output logic                             joy_data,
    output logic                             frame_done,
    output logic [$clog2(CHAIN_BITS+1)-1:0]  bits_shifted,
    output logic                             link_active
);

    localparam int CNT_W = $clog2(CHAIN_BITS + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES);

    logic [7:0]            joy1_r;
    logic [7:0]            joy2_r;
    logic [CHAIN_BITS-1:0] shreg_r;
    logic [CHAIN_BITS-1:0] shreg_next_s;
    logic [CHAIN_BITS-1:0] load_word_s;
    logic [CNT_W-1:0]      bits_r;
    logic [CNT_W-1:0]      bits_next_s;
    logic                  frame_done_r;
    logic                  frame_next_s;
    logic                  joy_data_r;
    logic [TO_W-1:0]       to_cnt_r;
    logic [TO_W-1:0]       to_cnt_next_s;
    logic                  link_r;
    logic                  link_next_s;

    logic clk_level_s;
    logic clk_rise_s;
    logic clk_fall_s;
    logic load_level_s;
    logic load_rise_s;
    logic load_fall_s;
    logic unused_ok_s;

    joy_shiftreg_responder_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_sync_clk (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (joy_clk),
        .level    (clk_level_s),
        .rise     (clk_rise_s),
        .fall     (clk_fall_s)
    );

    joy_shiftreg_responder_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_sync_load (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (joy_load_n),
        .level    (load_level_s),
        .rise     (load_rise_s),
        .fall     (load_fall_s)
    );

    assign unused_ok_s = &{1'b0, clk_level_s, clk_fall_s, load_rise_s};

    // Pad inputs registered once ahead of the load mux
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            joy1_r <= 8'h00;
            joy2_r <= 8'h00;
        end else begin
            joy1_r <= joy1;
            joy2_r <= joy2;
        end
    end

    // Load word: pad bytes in the top 16 bits, any extra chain bits idle high
    always_comb begin
        load_word_s = {CHAIN_BITS{1'b1}};
        load_word_s[CHAIN_BITS-1 -: PAD_WORD_BITS] = pack_chain(joy1_r, joy2_r);
    end

    // Chain next state: load dominates shift, serial-in tied high
    always_comb begin
        shreg_next_s = shreg_r;
        bits_next_s  = bits_r;
        frame_next_s = 1'b0;
        if (!load_level_s) begin
            shreg_next_s = load_word_s;
            bits_next_s  = {CNT_W{1'b0}};
        end else if (clk_rise_s) begin
            shreg_next_s = {shreg_r[CHAIN_BITS-2:0], 1'b1};
            if (bits_r != CNT_W'(CHAIN_BITS)) begin
                bits_next_s = bits_r + CNT_W'(1);
            end else begin
                bits_next_s = bits_r;
            end
            frame_next_s = (bits_r == CNT_W'(CHAIN_BITS - 1));
        end else begin
            shreg_next_s = shreg_r;
        end
    end

    // Chain, shift count, frame pulse and serial output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg_r      <= {CHAIN_BITS{1'b1}};
            bits_r       <= {CNT_W{1'b0}};
            frame_done_r <= 1'b0;
            joy_data_r   <= 1'b1;
        end else begin
            shreg_r      <= shreg_next_s;
            bits_r       <= bits_next_s;
            frame_done_r <= frame_next_s;
            joy_data_r   <= shreg_r[CHAIN_BITS-1];
        end
    end

    // Link watchdog next state: a load edge re-arms, otherwise count to timeout
    always_comb begin
        to_cnt_next_s = to_cnt_r;
        link_next_s   = link_r;
        if (load_fall_s) begin
            to_cnt_next_s = {TO_W{1'b0}};
            link_next_s   = 1'b1;
        end else if (to_cnt_r == TO_W'(TIMEOUT_CYCLES - 1)) begin
            to_cnt_next_s = to_cnt_r;
            link_next_s   = 1'b0;
        end else begin
            to_cnt_next_s = to_cnt_r + TO_W'(1);
            link_next_s   = link_r;
        end
    end

    // Link watchdog registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt_r <= {TO_W{1'b0}};
            link_r   <= 1'b0;
        end else begin
            to_cnt_r <= to_cnt_next_s;
            link_r   <= link_next_s;
        end
    end

    assign joy_data     = joy_data_r;
    assign frame_done   = frame_done_r;
    assign bits_shifted = bits_r;
    assign link_active  = link_r;

endmodule

// File: tb/tb_joy_shiftreg_responder.sv
// Directed + randomized bench for joy_shiftreg_responder with a
// bit-list reference model of the emulated 74HC165 chain.
module tb_joy_shiftreg_responder;

    localparam int HALF = 6;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] joy1 = 8'h00;
    logic [7:0] joy2 = 8'h00;
    logic       joy_clk = 1'b1;
    logic       joy_load_n = 1'b1;
    logic       joy_data;
    logic       frame_done;
    logic [4:0] bits_shifted;
    logic       link_active;

    int checks = 0;
    int errors = 0;
    int fd_count = 0;

    joy_shiftreg_responder #(
        .CHAIN_BITS     (16),
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .joy1         (joy1),
        .joy2         (joy2),
        .joy_clk      (joy_clk),
        .joy_load_n   (joy_load_n),
        .joy_data     (joy_data),
        .frame_done   (frame_done),
        .bits_shifted (bits_shifted),
        .link_active  (link_active)
    );

    always #5 clk = ~clk;

    // Count frame_done pulses seen away from the active edge
    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_count++;
    end

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [7:0] j1, input logic [7:0] j2);
        joy1 = j1;
        joy2 = j2;
        tick(2);
        joy_load_n = 1'b0;
        tick(HALF);
        joy_load_n = 1'b1;
        tick(HALF);
    endtask

    task automatic do_shift();
        joy_clk = 1'b0;
        tick(HALF);
        joy_clk = 1'b1;
        tick(HALF);
    endtask

    // Reference: bit i of the serial stream after a load
    function automatic logic model_bit(input logic [7:0] j1, input logic [7:0] j2, input int i);
        logic [15:0] word;
        word = ~{j1, j2};
        if (i < 16) return word[15 - i];
        return 1'b1;
    endfunction

    task automatic run_frame(input string tag, input logic [7:0] j1, input logic [7:0] j2,
                             input int n, output logic [31:0] stream);
        int fd_start;
        stream = 32'h0;
        do_load(j1, j2);
        fd_start = fd_count;
        for (int i = 0; i < n; i++) begin
            stream = {stream[30:0], joy_data};
            check({tag, "_bit"}, {31'h0, joy_data}, {31'h0, model_bit(j1, j2, i)});
            do_shift();
        end
        check({tag, "_count"}, {27'h0, bits_shifted}, (n >= 16) ? 32'd16 : n);
        check({tag, "_fdone"}, fd_count - fd_start, (n >= 16) ? 32'd1 : 32'd0);
    endtask

    initial begin
        logic [31:0] stream;
        logic [7:0]  r1;
        logic [7:0]  r2;
        int          n;
        int          wait_cnt;
        int          high_cnt;

        // Reset state
        tick(3);
        check("rst_data", {31'h0, joy_data}, 32'd1);
        check("rst_fdone", {31'h0, frame_done}, 32'd0);
        check("rst_bits", {27'h0, bits_shifted}, 32'd0);
        check("rst_link", {31'h0, link_active}, 32'd0);
        reset_n = 1'b1;
        tick(4);
        check("rel_bits", {27'h0, bits_shifted}, 32'd0);

        // Directed frame 81/00
        run_frame("f81", 8'h81, 8'h00, 16, stream);
        check("f81_stream", stream, 32'h0000_7EFF);

        // Shifts while load held low are ignored
        joy1 = 8'h35;
        joy2 = 8'hC2;
        tick(2);
        joy_load_n = 1'b0;
        tick(HALF);
        for (int i = 0; i < 3; i++) do_shift();
        check("ldlow_data", {31'h0, joy_data}, {31'h0, ~joy1[7]});
        check("ldlow_bits", {27'h0, bits_shifted}, 32'd0);
        joy_load_n = 1'b1;
        tick(HALF);

        // Overrun: all buttons pressed, 20 clocks
        run_frame("fff", 8'hFF, 8'hFF, 20, stream);
        check("fff_stream", stream, 32'h0000_000F);

        // Randomized frames against the model
        for (int f = 0; f < 5; f++) begin
            r1 = 8'($urandom);
            r2 = 8'($urandom);
            n  = $urandom_range(20, 10);
            run_frame("rnd", r1, r2, n, stream);
        end

        // Link watchdog: active for exactly TIMEOUT_CYCLES after the load edge
        tick(200);
        check("to_idle", {31'h0, link_active}, 32'd0);
        joy_load_n = 1'b0;
        wait_cnt = 0;
        while (link_active !== 1'b1 && wait_cnt < 20) begin
            wait_cnt++;
            tick(1);
        end
        check("to_rise", {31'h0, link_active}, 32'd1);
        high_cnt = 0;
        while (link_active === 1'b1 && high_cnt < 500) begin
            high_cnt++;
            tick(1);
        end
        check("to_len", high_cnt, 32'd100);
        joy_load_n = 1'b1;
        tick(HALF);
        joy_load_n = 1'b0;
        tick(HALF);
        check("to_rearm", {31'h0, link_active}, 32'd1);
        joy_load_n = 1'b1;
        tick(HALF);

        // Reset mid-frame after 7 shifts
        do_load(8'hFF, 8'h00);
        for (int i = 0; i < 7; i++) do_shift();
        check("mid_bits", {27'h0, bits_shifted}, 32'd7);
        check("mid_data", {31'h0, joy_data}, {31'h0, model_bit(8'hFF, 8'h00, 7)});
        check("mid_link", {31'h0, link_active}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("mrst_data", {31'h0, joy_data}, 32'd1);
        check("mrst_bits", {27'h0, bits_shifted}, 32'd0);
        check("mrst_link", {31'h0, link_active}, 32'd0);
        check("mrst_fdone", {31'h0, frame_done}, 32'd0);
        tick(3);
        reset_n = 1'b1;
        tick(4);
        do_shift();
        check("post_noload_data", {31'h0, joy_data}, 32'd1);

        // Recovery frame after reset
        run_frame("post", 8'hA5, 8'h3C, 16, stream);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
